ext_mem_bus_arb: RTL and testbench

Two-port arbiter and cycle sequencer for the external asynchronous memory bus: nCE0, nOE, nWE, XA0, A[15:0] and the bidirectional DB[7:0].
- Port 0 is the M65C02 core; port 1 is a secondary master (DMA/board-test engine).
- Grants one requester at a time and runs a fixed-timing SETUP/STROBE/HOLD access with a programmable wait-state count.
- Returns read data and a one-cycle acknowledge.
- All bus outputs are registered; DB tri-state control is exported for top-level pad instantiation.

---
 rtl/ext_mem_bus_arb.sv | 192 +++++++++++++++++++
 tb/tb_ext_mem_bus_arb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bus_arb.sv
// Two-port arbiter and SETUP/STROBE/HOLD sequencer for the external asynchronous memory bus.
// Define ARB_RR_EN for round-robin arbitration; by default port 0 has fixed priority.
module ext_mem_bus_arb #(
  parameter int unsigned pWS     = 2,
  parameter bit          pRstGnt = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        WE0,
  input  logic [16:0] Addr0,
  input  logic [7:0]  WDat0,
  output logic        Ack0,
  output logic [7:0]  RDat0,
  input  logic        Req1,
  input  logic        WE1,
  input  logic [16:0] Addr1,
  input  logic [7:0]  WDat1,
  output logic        Ack1,
  output logic [7:0]  RDat1,
  output logic        nCE0,
  output logic        nOE,
  output logic        nWE,
  output logic        XA0,
  output logic [15:0] A,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic [7:0]  DB_I,
  output logic        Busy
);

  localparam logic [3:0] WsLoad = 4'(pWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  dbO_q, dbO_d;
  logic        dbOE_q, dbOE_d;
  logic        nCE0_q, nCE0_d;
  logic        nOE_q, nOE_d;
  logic        nWE_q, nWE_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [7:0]  rDat0_q, rDat0_d;
  logic [7:0]  rDat1_q, rDat1_d;
`ifdef ARB_RR_EN
  logic        lastGnt_q, lastGnt_d;
`endif

  logic        reqAny;
  logic        gntSel;
  logic        selWe;
  logic [16:0] selAddr;
  logic [7:0]  selWDat;
  logic        capture;

  // Arbitration: gntSel is the index of the port that wins this IDLE cycle.
  always_comb begin
    reqAny = Req0 | Req1;
`ifdef ARB_RR_EN
    gntSel = (Req0 && Req1) ? ~lastGnt_q : ~Req0;
`else
    gntSel = ~Req0;
`endif
    selWe   = gntSel ? WE1   : WE0;
    selAddr = gntSel ? Addr1 : Addr0;
    selWDat = gntSel ? WDat1 : WDat0;
  end

  // Access sequencing and the wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dbO_d   = dbO_q;
`ifdef ARB_RR_EN
    lastGnt_d = lastGnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reqAny) begin
          state_d = SETUP;
          gnt_d   = gntSel;
          we_d    = selWe;
          addr_d  = selAddr;
          if (selWe) begin
            dbO_d = selWDat;
          end
`ifdef ARB_RR_EN
          lastGnt_d = gntSel;
`endif
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = WsLoad;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs are registered, so they are derived from the state being entered.
  always_comb begin
    nCE0_d  = (state_d == IDLE);
    nOE_d   = !((state_d == STROBE) && !we_d);
    nWE_d   = !((state_d == STROBE) && we_d);
    dbOE_d  = (state_d != IDLE) && we_d;
    ack0_d  = (state_d == HOLD) && !gnt_d;
    ack1_d  = (state_d == HOLD) && gnt_d;
    capture = (state_q == STROBE) && (state_d == HOLD) && !we_q;
    rDat0_d = (capture && !gnt_q) ? DB_I : rDat0_q;
    rDat1_d = (capture && gnt_q)  ? DB_I : rDat1_q;
  end

  // Synchronous reset drops every strobe on the next edge and discards any access in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 17'd0;
      dbO_q   <= 8'd0;
      dbOE_q  <= 1'b0;
      nCE0_q  <= 1'b1;
      nOE_q   <= 1'b1;
      nWE_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rDat0_q <= 8'd0;
      rDat1_q <= 8'd0;
`ifdef ARB_RR_EN
      lastGnt_q <= pRstGnt;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dbO_q   <= dbO_d;
      dbOE_q  <= dbOE_d;
      nCE0_q  <= nCE0_d;
      nOE_q   <= nOE_d;
      nWE_q   <= nWE_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rDat0_q <= rDat0_d;
      rDat1_q <= rDat1_d;
`ifdef ARB_RR_EN
      lastGnt_q <= lastGnt_d;
`endif
    end
  end

  assign nCE0  = nCE0_q;
  assign nOE   = nOE_q;
  assign nWE   = nWE_q;
  assign XA0   = addr_q[16];
  assign A     = addr_q[15:0];
  assign DB_O  = dbO_q;
  assign DB_OE = dbOE_q;
  assign Ack0  = ack0_q;
  assign Ack1  = ack1_q;
  assign RDat0 = rDat0_q;
  assign RDat1 = rDat1_q;
  assign Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ext_mem_bus_arb.sv
// Directed bench for ext_mem_bus_arb: three instances at pWS = 2, 0 and 15 share the request inputs.
// Expectations for the tie test follow the ARB_RR_EN define of the build.
module tb_ext_mem_bus_arb;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req0 = 1'b0, WE0 = 1'b0, Req1 = 1'b0, WE1 = 1'b0;
  logic [16:0] Addr0 = '0, Addr1 = '0;
  logic [7:0]  WDat0 = '0, WDat1 = '0, DBI = '0;

  logic        ack0W [3];
  logic        ack1W [3];
  logic        nCE0W [3];
  logic        nOEW  [3];
  logic        nWEW  [3];
  logic        xa0W  [3];
  logic        dbOEW [3];
  logic        busyW [3];
  logic [7:0]  rDat0W[3];
  logic [7:0]  rDat1W[3];
  logic [7:0]  dbOW  [3];
  logic [15:0] aW    [3];

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  ext_mem_bus_arb #(.pWS(2), .pRstGnt(1'b1)) u_dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .WE0(WE0), .Addr0(Addr0), .WDat0(WDat0), .Ack0(ack0W[0]), .RDat0(rDat0W[0]),
    .Req1(Req1), .WE1(WE1), .Addr1(Addr1), .WDat1(WDat1), .Ack1(ack1W[0]), .RDat1(rDat1W[0]),
    .nCE0(nCE0W[0]), .nOE(nOEW[0]), .nWE(nWEW[0]), .XA0(xa0W[0]), .A(aW[0]),
    .DB_O(dbOW[0]), .DB_OE(dbOEW[0]), .DB_I(DBI), .Busy(busyW[0])
  );

  ext_mem_bus_arb #(.pWS(0), .pRstGnt(1'b1)) u_ws0 (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .WE0(WE0), .Addr0(Addr0), .WDat0(WDat0), .Ack0(ack0W[1]), .RDat0(rDat0W[1]),
    .Req1(Req1), .WE1(WE1), .Addr1(Addr1), .WDat1(WDat1), .Ack1(ack1W[1]), .RDat1(rDat1W[1]),
    .nCE0(nCE0W[1]), .nOE(nOEW[1]), .nWE(nWEW[1]), .XA0(xa0W[1]), .A(aW[1]),
    .DB_O(dbOW[1]), .DB_OE(dbOEW[1]), .DB_I(DBI), .Busy(busyW[1])
  );

  ext_mem_bus_arb #(.pWS(15), .pRstGnt(1'b1)) u_ws15 (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .WE0(WE0), .Addr0(Addr0), .WDat0(WDat0), .Ack0(ack0W[2]), .RDat0(rDat0W[2]),
    .Req1(Req1), .WE1(WE1), .Addr1(Addr1), .WDat1(WDat1), .Ack1(ack1W[2]), .RDat1(rDat1W[2]),
    .nCE0(nCE0W[2]), .nOE(nOEW[2]), .nWE(nWEW[2]), .XA0(xa0W[2]), .A(aW[2]),
    .DB_O(dbOW[2]), .DB_OE(dbOEW[2]), .DB_I(DBI), .Busy(busyW[2])
  );

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with Rst low: the current cycle is IDLE cycle 0.
  task automatic doReset();
    Rst  = 1'b1;
    Req0 = 1'b0;
    Req1 = 1'b0;
    WE0  = 1'b0;
    WE1  = 1'b0;
    repeat (2) stepCycle();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Req0 = 1'b0;
    Req1 = 1'b0;
    stepCycle();
    stepCycle();
    tests++;
    if ({nCE0W[0], nOEW[0], nWEW[0], xa0W[0], dbOEW[0], ack0W[0], ack1W[0], busyW[0]} !== 8'b11100000) begin
      fails++;
      $display("[TB] FAIL reset_ctl got %b expected %b",
               {nCE0W[0], nOEW[0], nWEW[0], xa0W[0], dbOEW[0], ack0W[0], ack1W[0], busyW[0]}, 8'b11100000);
    end
    tests++;
    if (aW[0] !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_A got %h expected 0000", aW[0]);
    end
    tests++;
    if (dbOW[0] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_DB_O got %h expected 00", dbOW[0]);
    end
    tests++;
    if (rDat0W[0] !== 8'h00 || rDat1W[0] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_RDat got %h/%h expected 00/00", rDat0W[0], rDat1W[0]);
    end
    Rst = 1'b0;
  endtask

  task automatic test_read_ws2();
    logic [5:0] exp, got;
    doReset();
    Req0  = 1'b1;
    WE0   = 1'b0;
    Addr0 = 17'h12345;
    DBI   = 8'hA5;
    for (int c = 1; c <= 7; c++) begin
      stepCycle();
      exp = {!(c >= 1 && c <= 5), !(c >= 2 && c <= 4), 1'b1, (c == 5), (c >= 1 && c <= 5), 1'b0};
      got = {nCE0W[0], nOEW[0], nWEW[0], ack0W[0], busyW[0], dbOEW[0]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL read_ws2 cycle %0d ce/oe/we/ack/busy/oe_db got %b expected %b", c, got, exp);
      end
      if (c == 1) begin
        tests++;
        if ({xa0W[0], aW[0]} !== 17'h12345) begin
          fails++;
          $display("[TB] FAIL read_ws2_addr got %h expected 12345", {xa0W[0], aW[0]});
        end
      end
      if (c == 5) begin
        tests++;
        if (rDat0W[0] !== 8'hA5) begin
          fails++;
          $display("[TB] FAIL read_ws2_rdat got %h expected a5", rDat0W[0]);
        end
        Req0 = 1'b0;
        DBI  = 8'h00;
      end
    end
    tests++;
    if (rDat0W[0] !== 8'hA5 || rDat1W[0] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL read_ws2_hold got %h/%h expected a5/00", rDat0W[0], rDat1W[0]);
    end
  endtask

  task automatic test_write_ws0();
    logic [5:0] exp, got;
    doReset();
    Req1  = 1'b1;
    WE1   = 1'b1;
    Addr1 = 17'h000FF;
    WDat1 = 8'h3C;
    for (int c = 1; c <= 5; c++) begin
      stepCycle();
      exp = {!(c >= 1 && c <= 3), 1'b1, !(c == 2), 1'b0, (c == 3), (c >= 1 && c <= 3)};
      got = {nCE0W[1], nOEW[1], nWEW[1], ack0W[1], ack1W[1], dbOEW[1]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL write_ws0 cycle %0d ce/oe/we/ack0/ack1/oe_db got %b expected %b", c, got, exp);
      end
      if (c >= 1 && c <= 3) begin
        tests++;
        if (dbOW[1] !== 8'h3C) begin
          fails++;
          $display("[TB] FAIL write_ws0_dbo cycle %0d got %h expected 3c", c, dbOW[1]);
        end
      end
      if (c == 1) begin
        tests++;
        if ({xa0W[1], aW[1]} !== 17'h000FF) begin
          fails++;
          $display("[TB] FAIL write_ws0_addr got %h expected 000ff", {xa0W[1], aW[1]});
        end
      end
      if (c == 3) Req1 = 1'b0;
    end
  endtask

  task automatic test_arbitration();
    int firstAck0 = -1;
    int firstAck1 = -1;
    int nAck0 = 0;
    int nAck1 = 0;
    Rst   = 1'b1;
    Req0  = 1'b1;
    Req1  = 1'b1;
    WE0   = 1'b0;
    WE1   = 1'b0;
    Addr0 = 17'h00100;
    Addr1 = 17'h10200;
    DBI   = 8'h77;
    repeat (2) stepCycle();
    Rst = 1'b0;
`ifdef ARB_RR_EN
    for (int c = 1; c <= 14; c++) begin
      stepCycle();
      if (ack0W[0] && firstAck0 < 0) firstAck0 = c;
      if (ack1W[0] && firstAck1 < 0) firstAck1 = c;
      if (ack0W[0]) Req0 = 1'b0;
      if (ack1W[0]) Req1 = 1'b0;
      if (c == 6) begin
        tests++;
        if (nCE0W[0] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL rr_turnaround got nCE0=%b expected 1", nCE0W[0]);
        end
      end
      if (c == 7) begin
        tests++;
        if ({nCE0W[0], xa0W[0], aW[0]} !== {1'b0, 17'h10200}) begin
          fails++;
          $display("[TB] FAIL rr_port1_addr got %b/%h expected 0/10200", nCE0W[0], {xa0W[0], aW[0]});
        end
      end
    end
    tests++;
    if (firstAck0 != 5 || firstAck1 != 11) begin
      fails++;
      $display("[TB] FAIL rr_order got Ack0@%0d Ack1@%0d expected Ack0@5 Ack1@11", firstAck0, firstAck1);
    end
`else
    for (int c = 1; c <= 24; c++) begin
      stepCycle();
      if (ack0W[0]) nAck0++;
      if (ack1W[0]) begin
        nAck1++;
        if (firstAck1 < 0) firstAck1 = c;
      end
      if (c == 17) Req0 = 1'b0;
      if (c == 19) begin
        tests++;
        if ({xa0W[0], aW[0]} !== 17'h10200) begin
          fails++;
          $display("[TB] FAIL fixed_port1_addr got %h expected 10200", {xa0W[0], aW[0]});
        end
      end
      if (ack1W[0]) Req1 = 1'b0;
    end
    tests++;
    if (nAck0 != 3 || nAck1 != 1 || firstAck1 != 23) begin
      fails++;
      $display("[TB] FAIL fixed_prio got Ack0 x%0d Ack1 x%0d first Ack1@%0d expected 3, 1, 23",
               nAck0, nAck1, firstAck1);
    end
`endif
    Req0 = 1'b0;
    Req1 = 1'b0;
    tests++;
    if (firstAck0 == 5 || firstAck0 == -1) begin
      if (rDat1W[0] === 8'h77 || nAck1 > 0) begin
        if (rDat1W[0] !== 8'h77) begin
          fails++;
          $display("[TB] FAIL arb_rdat1 got %h expected 77", rDat1W[0]);
        end
      end else begin
        fails++;
        $display("[TB] FAIL arb_rdat1 got %h expected 77", rDat1W[0]);
      end
    end else begin
      fails++;
      $display("[TB] FAIL arb_first_ack0 got %0d expected 5", firstAck0);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [4:0] exp, got;
    int ackSeen = 0;
    doReset();
    Req0  = 1'b1;
    WE0   = 1'b1;
    Addr0 = 17'h00010;
    WDat0 = 8'h5A;
    repeat (3) stepCycle();
    tests++;
    if ({nWEW[0], dbOEW[0]} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL midrst_strobe got nWE/DB_OE=%b expected 01", {nWEW[0], dbOEW[0]});
    end
    Rst  = 1'b1;
    Req0 = 1'b0;
    stepCycle();
    tests++;
    if ({nWEW[0], nCE0W[0], nOEW[0], dbOEW[0], ack0W[0], busyW[0]} !== 6'b111000) begin
      fails++;
      $display("[TB] FAIL midrst_release got %b expected 111000",
               {nWEW[0], nCE0W[0], nOEW[0], dbOEW[0], ack0W[0], busyW[0]});
    end
    Rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      if (ack0W[0]) ackSeen++;
    end
    tests++;
    if (ackSeen != 0) begin
      fails++;
      $display("[TB] FAIL midrst_noack got %0d Ack0 pulses expected 0", ackSeen);
    end
    Req0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      stepCycle();
      exp = {!(c >= 1 && c <= 5), !(c >= 2 && c <= 4), 1'b1, (c >= 1 && c <= 5), (c == 5)};
      got = {nCE0W[0], nWEW[0], nOEW[0], dbOEW[0], ack0W[0]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL midrst_retry cycle %0d ce/we/oe/oe_db/ack got %b expected %b", c, got, exp);
      end
      if (c == 3) begin
        tests++;
        if (dbOW[0] !== 8'h5A) begin
          fails++;
          $display("[TB] FAIL midrst_retry_dbo got %h expected 5a", dbOW[0]);
        end
      end
      if (c == 5) Req0 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp, got;
    logic [7:0]  expData;
    doReset();
    Req0  = 1'b1;
    WE0   = 1'b0;
    Addr0 = 17'h0ABCD;
    DBI   = 8'h11;
    for (int c = 1; c <= 18; c++) begin
      stepCycle();
      exp = {(c == 6 || c == 12 || c == 18), (c % 6 == 5)};
      got = {nCE0W[0], ack0W[0]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL b2b cycle %0d nCE0/Ack0 got %b expected %b", c, got, exp);
      end
      if (c % 6 == 5) begin
        expData = (c == 5) ? 8'h11 : ((c == 11) ? 8'h22 : 8'h33);
        tests++;
        if (rDat0W[0] !== expData) begin
          fails++;
          $display("[TB] FAIL b2b_rdat cycle %0d got %h expected %h", c, rDat0W[0], expData);
        end
        DBI = expData + 8'h11;
        if (c == 17) Req0 = 1'b0;
      end
    end
  endtask

  task automatic test_ws15();
    logic [2:0] exp, got;
    int oeLow = 0;
    doReset();
    Req0  = 1'b1;
    WE0   = 1'b0;
    Addr0 = 17'h1FFFF;
    DBI   = 8'hC3;
    for (int c = 1; c <= 20; c++) begin
      stepCycle();
      if (nOEW[2] === 1'b0) oeLow++;
      exp = {!(c >= 1 && c <= 18), !(c >= 2 && c <= 17), (c == 18)};
      got = {nCE0W[2], nOEW[2], ack0W[2]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL ws15 cycle %0d nCE0/nOE/Ack0 got %b expected %b", c, got, exp);
      end
      if (c == 18) begin
        tests++;
        if (rDat0W[2] !== 8'hC3) begin
          fails++;
          $display("[TB] FAIL ws15_rdat got %h expected c3", rDat0W[2]);
        end
        Req0 = 1'b0;
      end
    end
    tests++;
    if (oeLow != 16 || busyW[2] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ws15_len got nOE low %0d cycles, Busy=%b expected 16, 0", oeLow, busyW[2]);
    end
  endtask

  initial begin
    test_reset();
    test_read_ws2();
    test_write_ws0();
    test_arbitration();
    test_reset_mid_write();
    test_back_to_back();
    test_ws15();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
